// File: rtl/retire_trace_ctrl.sv
// Retire trace sequencer: buffers retired-instruction events and presents each one to the
// checker together with the shadow register file state after that instruction retires.
module retire_trace_ctrl #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int NREGS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  retire_valid,
  output logic                  retire_ready,
  input  logic [XLEN-1:0]       retire_instr,
  input  logic                  retire_rd_we,
  input  logic [$clog2(NREGS)-1:0] retire_rd,
  input  logic [XLEN-1:0]       retire_rd_data,
  output logic                  chk_valid,
  input  logic                  chk_ready,
  output logic [XLEN-1:0]       chk_instr,
  output logic [NREGS*XLEN-1:0] chk_regs,
  output logic                  overflow,
  output logic [31:0]           chk_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(NREGS);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t          state;
  logic [XLEN-1:0] mem_instr [DEPTH];
  logic            mem_we    [DEPTH];
  logic [RW-1:0]   mem_rd    [DEPTH];
  logic [XLEN-1:0] mem_data  [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [XLEN-1:0] regs [NREGS];

  logic empty;
  logic push;
  logic pop;
  logic handshake;

  assign empty        = (count == '0);
  assign retire_ready = (count != FULL_CNT);
  assign push         = retire_valid && retire_ready && !flush;
  // IDLE drains the head on its own; PRESENT only advances when the checker takes the snapshot
  assign pop          = !flush && !empty && ((state == IDLE) || chk_ready);
  assign handshake    = chk_valid && chk_ready && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= retire_instr;
      mem_we[wr_ptr]    <= retire_rd_we;
      mem_rd[wr_ptr]    <= retire_rd;
      mem_data[wr_ptr]  <= retire_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (retire_valid && !retire_ready)
      overflow <= 1'b1;
  end

  // Shadow register update happens at pop so chk_regs reflects state right after the presented instr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      chk_valid <= 1'b0;
      chk_instr <= '0;
      chk_count <= '0;
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    end else begin
      if (handshake) chk_count <= chk_count + 32'd1;
      if (flush) begin
        state     <= IDLE;
        chk_valid <= 1'b0;
      end else if (pop) begin
        chk_instr <= mem_instr[rd_ptr];
        if (mem_we[rd_ptr] && (mem_rd[rd_ptr] != '0))
          regs[mem_rd[rd_ptr]] <= mem_data[rd_ptr];
        state     <= PRESENT;
        chk_valid <= 1'b1;
      end else if ((state == PRESENT) && chk_ready) begin
        state     <= IDLE;
        chk_valid <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    assign chk_regs[g*XLEN +: XLEN] = regs[g];
  end

endmodule

// File: tb/tb_retire_trace_ctrl.sv
// Directed self-checking bench for retire_trace_ctrl with hand-computed expectations.
module tb_retire_trace_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         retire_valid = 1'b0;
  logic         retire_ready;
  logic [31:0]  retire_instr = '0;
  logic         retire_rd_we = 1'b0;
  logic [3:0]   retire_rd = '0;
  logic [31:0]  retire_rd_data = '0;
  logic         chk_valid;
  logic         chk_ready = 1'b0;
  logic [31:0]  chk_instr;
  logic [511:0] chk_regs;
  logic         overflow;
  logic [31:0]  chk_count;

  int errors = 0;
  int checks = 0;

  retire_trace_ctrl #(.DEPTH(8), .XLEN(32), .NREGS(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .retire_valid(retire_valid), .retire_ready(retire_ready),
    .retire_instr(retire_instr), .retire_rd_we(retire_rd_we),
    .retire_rd(retire_rd), .retire_rd_data(retire_rd_data),
    .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_instr(chk_instr),
    .chk_regs(chk_regs), .overflow(overflow), .chk_count(chk_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic we,
                               input logic [3:0] rd, input logic [31:0] data);
    retire_valid   = v;
    retire_instr   = instr;
    retire_rd_we   = we;
    retire_rd      = rd;
    retire_rd_data = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_of(input int k);
    return chk_regs[k*32 +: 32];
  endfunction

  initial begin
    // reset state
    #12 rst_n = 1'b1;
    step();
    checkOutput("rst_valid", {31'd0, chk_valid}, 32'd0);
    checkOutput("rst_count", chk_count, 32'd0);
    checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("rst_ready", {31'd0, retire_ready}, 32'd1);
    checkOutput("rst_instr", chk_instr, 32'd0);

    // single addi x5, x0, 10
    chk_ready = 1'b1;
    applyStimulus(1'b1, 32'h00A00293, 1'b1, 4'd5, 32'd10);
    step();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("addi_lat0", {31'd0, chk_valid}, 32'd0);
    step();
    checkOutput("addi_valid", {31'd0, chk_valid}, 32'd1);
    checkOutput("addi_instr", chk_instr, 32'h00A00293);
    checkOutput("addi_x5", reg_of(5), 32'd10);
    step();
    checkOutput("addi_count", chk_count, 32'd1);
    checkOutput("addi_idle", {31'd0, chk_valid}, 32'd0);

    // write to x0 must be ignored
    applyStimulus(1'b1, 32'h00000013, 1'b1, 4'd0, 32'h0000DEAD);
    step();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    step();
    checkOutput("x0_valid", {31'd0, chk_valid}, 32'd1);
    checkOutput("x0_zero", reg_of(0), 32'd0);
    checkOutput("x0_x5", reg_of(5), 32'd10);
    step();
    checkOutput("x0_count", chk_count, 32'd2);

    // fill: 1 presented + 8 buffered, then overflow
    chk_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("fill_ready%0d", i), {31'd0, retire_ready}, 32'd1);
      applyStimulus(1'b1, 32'h100 + i, 1'b1, 4'(i + 1), 32'h1000 + i);
      step();
    end
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("full_ready", {31'd0, retire_ready}, 32'd0);
    checkOutput("full_ovf0", {31'd0, overflow}, 32'd0);
    applyStimulus(1'b1, 32'h0BAD0BAD, 1'b1, 4'd15, 32'hFFFFFFFF);
    step();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("full_ovf1", {31'd0, overflow}, 32'd1);
    checkOutput("full_hold", chk_instr, 32'h100);
    chk_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("drain_valid%0d", i), {31'd0, chk_valid}, 32'd1);
      checkOutput($sformatf("drain_instr%0d", i), chk_instr, 32'h100 + i);
      checkOutput($sformatf("drain_reg%0d", i), reg_of(i + 1), 32'h1000 + i);
      step();
    end
    checkOutput("drain_idle", {31'd0, chk_valid}, 32'd0);
    checkOutput("drain_count", chk_count, 32'd11);
    checkOutput("drain_x15", reg_of(15), 32'd0);

    // back-pressure with chk_ready toggling 1010..
    chk_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h200 + i, 1'b1, 4'(10 + i), 32'h2000 + i);
      step();
    end
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    begin
      int idx;
      idx = 0;
      for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
        chk_ready = (cyc % 2 == 0);
        checkOutput($sformatf("bp_valid%0d", cyc), {31'd0, chk_valid}, 32'd1);
        checkOutput($sformatf("bp_instr%0d", cyc), chk_instr, 32'h200 + idx);
        checkOutput($sformatf("bp_reg%0d", cyc), reg_of(10 + idx), 32'h2000 + idx);
        step();
        if (chk_ready) idx++;
      end
    end
    chk_ready = 1'b0;
    checkOutput("bp_idle", {31'd0, chk_valid}, 32'd0);
    checkOutput("bp_count", chk_count, 32'd15);

    // flush with 1 presented + 3 buffered, colliding with push and handshake
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h300 + i, 1'b1, 4'(i + 1), 32'h3000 + i);
      step();
    end
    checkOutput("fl_pre_valid", {31'd0, chk_valid}, 32'd1);
    applyStimulus(1'b1, 32'h0000ABCD, 1'b1, 4'd7, 32'h0000ABCD);
    flush = 1'b1;
    chk_ready = 1'b1;
    step();
    flush = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("fl_valid", {31'd0, chk_valid}, 32'd0);
    checkOutput("fl_count", chk_count, 32'd15);
    checkOutput("fl_x1", reg_of(1), 32'h3000);
    checkOutput("fl_x2", reg_of(2), 32'h1001);
    checkOutput("fl_x7", reg_of(7), 32'h1006);
    checkOutput("fl_ready", {31'd0, retire_ready}, 32'd1);
    step();
    step();
    checkOutput("fl_empty", {31'd0, chk_valid}, 32'd0);
    checkOutput("fl_count2", chk_count, 32'd15);

    // async reset mid-PRESENT, no clock edge
    chk_ready = 1'b0;
    applyStimulus(1'b1, 32'h00500513, 1'b1, 4'd10, 32'd5);
    step();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    step();
    checkOutput("ar_pre_valid", {31'd0, chk_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", {31'd0, chk_valid}, 32'd0);
    checkOutput("ar_count", chk_count, 32'd0);
    checkOutput("ar_instr", chk_instr, 32'd0);
    checkOutput("ar_regs", {31'd0, (chk_regs == '0)}, 32'd1);
    checkOutput("ar_ovf", {31'd0, overflow}, 32'd0);
    #1 rst_n = 1'b1;
    step();
    checkOutput("ar_after", {31'd0, chk_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
